// File: rtl/instr_issue_queue.sv
// Circular instruction FIFO feeding a one-deep output register via valid/ready; FSM IDLE/RUN/HALT.
// Latency: push-to-valid and start-to-valid 2 cycles; backpressure holds instr, a full FIFO drops writes.
// Optional macro ILLEGAL_OP_TRAP_EN: an illegal opcode also sends the FSM to HALT.
module instr_issue_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_data,
    output logic          full,
    input  logic          start,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          busy,
    output logic          halted,
    output logic [7:0]    issued_cnt,
    output logic [3:0]    illegal_cnt,
    output logic          err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t        state;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          empty, push, pop, out_free;
    logic [IW-1:0] head;
    logic [3:0]    op;
    logic          op_legal, op_halt, op_illegal;

    assign empty      = (cnt == '0);
    assign full       = (cnt == DEPTH_CNT);
    assign head       = mem[rptr];
    assign op         = head[IW-1:IW-4];
    assign op_legal   = (op == 4'hB) || (op == 4'hC) || (op == 4'hD) || (op == 4'h8);
    assign op_halt    = (op == 4'h0);
    assign op_illegal = !op_legal && !op_halt;

    // Full blocks writes outright, even if a pop would make room this cycle.
    assign push     = wr_en && !full;
    assign out_free = !instr_valid || instr_ready;
    assign pop      = (state == S_RUN) && out_free && !empty;

    assign busy   = (state == S_RUN) && (!empty || instr_valid);
    assign halted = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= '0;
            state       <= S_IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            issued_cnt  <= '0;
            illegal_cnt <= '0;
            err         <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase

            case (state)
                S_IDLE: if (start) state <= S_RUN;
                S_RUN: begin
                    if (pop && op_halt) state <= S_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
                    if (pop && op_illegal) state <= S_HALT;
`endif
                end
                S_HALT: if (start) state <= S_RUN;
                default: state <= S_IDLE;
            endcase

            // A free register either reloads with a legal word or goes empty.
            if (out_free) begin
                instr_valid <= pop && op_legal;
                if (pop && op_legal) instr <= head;
            end

            if (pop && op_illegal) begin
                err <= 1'b1;
                if (illegal_cnt != 4'hF) illegal_cnt <= illegal_cnt + 4'd1;
            end

            if (instr_valid && instr_ready) issued_cnt <= issued_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_instr_issue_queue.sv
// Scoreboard bench for instr_issue_queue: expected issue words queued at push time, compared on each transfer.
module tb_instr_issue_queue;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [IW-1:0] wr_data;
    logic          full;
    logic          start;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          busy;
    logic          halted;
    logic [7:0]    issued_cnt;
    logic [3:0]    illegal_cnt;
    logic          err;

    int checks   = 0;
    int failures = 0;
    logic [IW-1:0] sb[$];

    instr_issue_queue #(.DEPTH(8), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .start(start), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .busy(busy), .halted(halted), .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Transfers happen on the next rising edge; inputs change only at posedge+1.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) check("spurious_issue", {16'h0, instr}, 32'hFFFF_FFFF);
            else                check("issue_order", {16'h0, instr}, {16'h0, sb.pop_front()});
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic push(input logic [IW-1:0] w, input bit expect_issue);
        wr_en   = 1'b1;
        wr_data = w;
        if (expect_issue) sb.push_back(w);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || instr_valid) && n < budget) begin
            step(1);
            n++;
        end
        if (sb.size() != 0 || instr_valid) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic load4();
        push(16'hBD21, 1'b1);
        push(16'hCE25, 1'b1);
        push(16'hDF5B, 1'b1);
        push(16'h867A, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; instr_ready = 1'b1;
        #2;
        do_reset();
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_illegal", illegal_cnt, 0);
        check("rst_err", err, 0);

        // Basic issue: 2-cycle start latency, then back-to-back.
        load4();
        check("idle_no_issue", instr_valid, 0);
        pulse_start();
        check("start_lat_1", instr_valid, 0);
        step(1);
        check("first_instr", instr, 16'hBD21);
        for (int i = 0; i < 4; i++) begin
            check("back_to_back", instr_valid, 1);
            step(1);
        end
        check("basic_valid_end", instr_valid, 0);
        check("basic_issued", issued_cnt, 4);
        check("basic_busy", busy, 0);

        // Backpressure holds the head word.
        do_reset();
        instr_ready = 1'b0;
        load4();
        pulse_start();
        step(1);
        for (int i = 0; i < 3; i++) begin
            check("bp_instr", instr, 16'hBD21);
            check("bp_valid", instr_valid, 1);
            check("bp_issued", issued_cnt, 0);
            step(1);
        end
        instr_ready = 1'b1;
        wait_drain(20);
        check("bp_issued_end", issued_cnt, 4);

        // Illegal opcode.
        do_reset();
`ifdef ILLEGAL_OP_TRAP_EN
        push(16'h3123, 1'b0);
        push(16'hBD21, 1'b0);
        pulse_start();
        step(4);
        check("trap_halted", halted, 1);
        check("trap_issued", issued_cnt, 0);
        check("trap_illegal", illegal_cnt, 1);
        check("trap_err", err, 1);
        sb.push_back(16'hBD21);
        pulse_start();
        wait_drain(20);
        check("trap_issued_end", issued_cnt, 1);
`else
        push(16'h3123, 1'b0);
        push(16'hBD21, 1'b1);
        pulse_start();
        wait_drain(20);
        check("ill_issued", issued_cnt, 1);
        check("ill_cnt", illegal_cnt, 1);
        check("ill_err", err, 1);
        check("ill_not_halted", halted, 0);
`endif

        // HALT word stops issue until the next start.
        do_reset();
        push(16'hBD21, 1'b1);
        push(16'h0000, 1'b0);
        push(16'hCE25, 1'b1);
        pulse_start();
        step(5);
        check("halt_halted", halted, 1);
        check("halt_issued", issued_cnt, 1);
        check("halt_valid", instr_valid, 0);
        check("halt_busy", busy, 0);
        pulse_start();
        wait_drain(20);
        check("halt_resume_issued", issued_cnt, 2);
        check("halt_resume_state", halted, 0);

        // Full drop and pointer wrap.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            check("not_full_before", full, 0);
            push(16'hB000 + 16'(i), 1'b1);
        end
        check("full_at_8", full, 1);
        push(16'hB009, 1'b0);
        check("full_after_drop", full, 1);
        pulse_start();
        wait_drain(30);
        check("full_issued", issued_cnt, 8);
        for (int i = 10; i <= 13; i++) push(16'hB000 + 16'(i), 1'b1);
        wait_drain(30);
        check("wrap_issued", issued_cnt, 12);
        check("wrap_full", full, 0);

        // Asynchronous reset mid-stream.
        do_reset();
        instr_ready = 1'b0;
        load4();
        pulse_start();
        step(1);
        check("pre_rst_valid", instr_valid, 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_instr", instr, 0);
        check("arst_busy", busy, 0);
        check("arst_issued", issued_cnt, 0);
        step(2);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        step(1);
        pulse_start();
        step(8);
        check("post_rst_issued", issued_cnt, 0);
        check("post_rst_valid", instr_valid, 0);
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
